// File: rtl/dmem_ctrl.sv
// Data-memory access controller: aligns CPU byte/half/word loads and stores onto a
// big-endian 32-bit memory port, with alignment checking and an ack timeout.
module dmem_ctrl #(
   parameter int TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        wr,
   input  logic [0:31] addr,
   input  logic [1:0]  DSize,
   input  logic        loadSign,
   input  logic [0:31] wdata,
   output logic        stall,
   output logic        done,
   output logic [0:31] rdata,
   output logic        misalign,
   output logic        buserr,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [0:31] mem_addr,
   output logic [0:3]  mem_be,
   output logic [0:31] mem_wdata,
   input  logic [0:31] mem_rdata,
   input  logic        mem_ack
);

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t          state_r;
   logic   [CW-1:0] cnt_r;
   logic   [1:0]    capSize_r;
   logic   [1:0]    capOff_r;
   logic            capSign_r;

   function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] off);
      logic bad;
      case (size)
         2'd0:    bad = 1'b0;
         2'd1:    bad = off[0];
         2'd3:    bad = (off != 2'd0);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   function automatic logic [0:3] byteEnables(input logic [1:0] size, input logic [1:0] off);
      logic [0:3] be;
      case (size)
         2'd0:    be = 4'b1000 >> off;
         2'd1:    be = off[1] ? 4'b0011 : 4'b1100;
         2'd3:    be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

   function automatic logic [0:31] storeLanes(input logic [1:0] size, input logic [0:31] wd);
      logic [0:31] lanes;
      case (size)
         2'd0:    lanes = {4{wd[24:31]}};
         2'd1:    lanes = {2{wd[16:31]}};
         default: lanes = wd;
      endcase
      return lanes;
   endfunction

   // Lane 0 is the most significant byte of the memory word (big-endian).
   function automatic logic [0:31] loadExtract(input logic [1:0] size, input logic [1:0] off,
                                               input logic sgn, input logic [0:31] md);
      logic [7:0]  b;
      logic [15:0] h;
      logic [0:31] r;
      case (off)
         2'd0:    b = md[0:7];
         2'd1:    b = md[8:15];
         2'd2:    b = md[16:23];
         default: b = md[24:31];
      endcase
      h = off[1] ? md[16:31] : md[0:15];
      case (size)
         2'd0:    r = {{24{sgn & b[7]}}, b};
         2'd1:    r = {{16{sgn & h[15]}}, h};
         default: r = md;
      endcase
      return r;
   endfunction

   assign stall = req & ~done;

   // Access sequencer: all outputs except stall are registered here.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r   <= IDLE;
         cnt_r     <= '0;
         capSize_r <= 2'd0;
         capOff_r  <= 2'd0;
         capSign_r <= 1'b0;
         done      <= 1'b0;
         misalign  <= 1'b0;
         buserr    <= 1'b0;
         rdata     <= 32'h0000_0000;
         mem_req   <= 1'b0;
         mem_wr    <= 1'b0;
         mem_addr  <= 32'h0000_0000;
         mem_be    <= 4'b0000;
         mem_wdata <= 32'h0000_0000;
      end else begin
         case (state_r)
            IDLE: begin
               done     <= 1'b0;
               misalign <= 1'b0;
               buserr   <= 1'b0;
               if (req) begin
                  capSize_r <= DSize;
                  capOff_r  <= addr[30:31];
                  capSign_r <= loadSign;
                  if (isMisaligned(DSize, addr[30:31])) begin
                     state_r  <= RESP;
                     done     <= 1'b1;
                     misalign <= 1'b1;
                     rdata    <= 32'h0000_0000;
                  end else begin
                     state_r   <= ACCESS;
                     cnt_r     <= '0;
                     mem_req   <= 1'b1;
                     mem_wr    <= wr;
                     mem_addr  <= {addr[0:29], 2'b00};
                     mem_be    <= byteEnables(DSize, addr[30:31]);
                     mem_wdata <= storeLanes(DSize, wdata);
                  end
               end
            end
            ACCESS: begin
               // An ack in the final allowed cycle still completes normally.
               if (mem_ack) begin
                  state_r <= RESP;
                  done    <= 1'b1;
                  rdata   <= mem_wr ? 32'h0000_0000
                                    : loadExtract(capSize_r, capOff_r, capSign_r, mem_rdata);
                  mem_req <= 1'b0;
                  mem_wr  <= 1'b0;
                  mem_be  <= 4'b0000;
               end else if (cnt_r == CW'(TIMEOUT - 1)) begin
                  state_r <= RESP;
                  done    <= 1'b1;
                  buserr  <= 1'b1;
                  rdata   <= 32'h0000_0000;
                  mem_req <= 1'b0;
                  mem_wr  <= 1'b0;
                  mem_be  <= 4'b0000;
               end else begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end
            RESP: begin
               state_r  <= IDLE;
               cnt_r    <= '0;
               done     <= 1'b0;
               misalign <= 1'b0;
               buserr   <= 1'b0;
            end
            default: begin
               state_r  <= IDLE;
               cnt_r    <= '0;
               done     <= 1'b0;
               misalign <= 1'b0;
               buserr   <= 1'b0;
               mem_req  <= 1'b0;
               mem_wr   <= 1'b0;
               mem_be   <= 4'b0000;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: the driver queues expected responses, a memory
// model acks after a programmed delay, and a monitor checks every done pulse.
module tb_dmem_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req = 1'b0, wr = 1'b0, loadSign = 1'b0;
   logic [0:31] addr = 32'h0, wdata = 32'h0;
   logic [1:0]  DSize = 2'd0;
   logic        stall, done, misalign, buserr, mem_req, mem_wr;
   logic [0:31] rdata, mem_addr, mem_wdata;
   logic [0:3]  mem_be;
   logic [0:31] mem_rdata = 32'h0;
   logic        mem_ack = 1'b0;

   dmem_ctrl #(.TIMEOUT(15)) dut (
      .clk(clk), .reset(reset), .req(req), .wr(wr), .addr(addr), .DSize(DSize),
      .loadSign(loadSign), .wdata(wdata), .stall(stall), .done(done), .rdata(rdata),
      .misalign(misalign), .buserr(buserr), .mem_req(mem_req), .mem_wr(mem_wr),
      .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rdata;
      logic        chkRdata;
      logic        mis;
      logic        berr;
      logic        hit;
      logic [3:0]  be;
      logic [31:0] wdat;
      logic [31:0] maddr;
      logic        wrr;
      int          cycles;
      int          lat;
   } exp_t;

   exp_t q[$];
   int compared = 0, mismatched = 0;
   int cyc = 0, issueCyc = 0;
   int ackDelay = -1, waitCnt = 0, reqCycles = 0;
   logic        seenReq = 1'b0, gotWr = 1'b0;
   logic [3:0]  gotBe = 4'h0;
   logic [31:0] gotWdata = 32'h0, gotAddr = 32'h0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic [31:0] rd, input logic chkRd, input logic mis,
                               input logic berr, input logic hit, input logic [3:0] be,
                               input logic [31:0] wd, input logic [31:0] ma, input logic w,
                               input int cycles, input int lat);
      exp_t e;
      e.rdata = rd; e.chkRdata = chkRd; e.mis = mis; e.berr = berr; e.hit = hit;
      e.be = be; e.wdat = wd; e.maddr = ma; e.wrr = w; e.cycles = cycles; e.lat = lat;
      return e;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: records the request, acks ackDelay cycles after mem_req rises.
   initial begin
      forever begin
         @(negedge clk);
         mem_ack = 1'b0;
         if (mem_req) begin
            if (!seenReq) begin
               seenReq  = 1'b1;
               gotBe    = mem_be;
               gotWdata = mem_wdata;
               gotAddr  = mem_addr;
               gotWr    = mem_wr;
               waitCnt  = 0;
            end else begin
               waitCnt++;
            end
            reqCycles++;
            if (waitCnt == ackDelay) mem_ack = 1'b1;
         end
      end
   end

   // Monitor: each done pulse must match the oldest queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (done) begin
            if (q.size() == 0) begin
               chk("unexpected_done", 32'(done), 32'd0);
            end else begin
               e = q.pop_front();
               chk("misalign", 32'(misalign), 32'(e.mis));
               chk("buserr", 32'(buserr), 32'(e.berr));
               chk("latency", 32'(cyc - issueCyc), 32'(e.lat));
               chk("mem_req_seen", 32'(seenReq), 32'(e.hit));
               if (e.chkRdata) chk("rdata", rdata, e.rdata);
               if (e.hit) begin
                  chk("mem_be", 32'(gotBe), 32'(e.be));
                  chk("mem_wdata", gotWdata, e.wdat);
                  chk("mem_addr", gotAddr, e.maddr);
                  chk("mem_wr", 32'(gotWr), 32'(e.wrr));
                  chk("req_cycles", 32'(reqCycles), 32'(e.cycles));
               end
            end
         end
      end
   end

   task automatic runAcc(input logic w, input logic [31:0] a, input logic [1:0] sz,
                         input logic sg, input logic [31:0] wd, input logic [31:0] md,
                         input int dly, input exp_t e);
      @(negedge clk);
      q.push_back(e);
      seenReq = 1'b0; reqCycles = 0; ackDelay = dly; mem_rdata = md; issueCyc = cyc;
      req = 1'b1; wr = w; addr = a; DSize = sz; loadSign = sg; wdata = wd;
      #1 chk("stall_on_req", 32'(stall), 32'd1);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) break;
      end
      if (!done) chk("done_timeout", 32'(done), 32'd1);
      req = 1'b0;
   endtask

   localparam logic [31:0] MD = 32'hF123_4567;
   localparam logic [31:0] WD = 32'h1122_3344;

   initial begin
      #12;
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_misalign", 32'(misalign), 32'd0);
      chk("rst_buserr", 32'(buserr), 32'd0);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_wr", 32'(mem_wr), 32'd0);
      chk("rst_mem_be", 32'(mem_be), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      #10 reset = 1'b0;

      // Loads: byte lanes, halves, words, with sign/zero extension.
      runAcc(1'b0, 32'h1000_0001, 2'd0, 1'b1, WD, MD, 3,
             mk(32'h0000_0023, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0100, 32'h4444_4444, 32'h1000_0000, 1'b0, 4, 5));
      runAcc(1'b0, 32'h1000_0000, 2'd0, 1'b1, WD, MD, 0,
             mk(32'hFFFF_FFF1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1000, 32'h4444_4444, 32'h1000_0000, 1'b0, 1, 2));
      runAcc(1'b0, 32'h1000_0003, 2'd0, 1'b0, WD, MD, 1,
             mk(32'h0000_0067, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0001, 32'h4444_4444, 32'h1000_0000, 1'b0, 2, 3));
      runAcc(1'b0, 32'h1000_0000, 2'd1, 1'b0, WD, MD, 0,
             mk(32'h0000_F123, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1100, 32'h3344_3344, 32'h1000_0000, 1'b0, 1, 2));
      runAcc(1'b0, 32'h1000_0000, 2'd1, 1'b1, WD, MD, 0,
             mk(32'hFFFF_F123, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1100, 32'h3344_3344, 32'h1000_0000, 1'b0, 1, 2));
      runAcc(1'b0, 32'h1000_0002, 2'd1, 1'b1, WD, MD, 0,
             mk(32'h0000_4567, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0011, 32'h3344_3344, 32'h1000_0000, 1'b0, 1, 2));
      runAcc(1'b0, 32'h1000_0004, 2'd3, 1'b0, WD, MD, 0,
             mk(32'hF123_4567, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1111, WD, 32'h1000_0004, 1'b0, 1, 2));
      runAcc(1'b0, 32'h1000_0004, 2'd3, 1'b1, WD, MD, 2,
             mk(32'hF123_4567, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1111, WD, 32'h1000_0004, 1'b0, 3, 4));

      // Stores: lane replication and write strobe.
      runAcc(1'b1, 32'h2000_0002, 2'd1, 1'b0, 32'hAAAA_5678, MD, 0,
             mk(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0011, 32'h5678_5678, 32'h2000_0000, 1'b1, 1, 2));
      runAcc(1'b1, 32'h2000_0001, 2'd0, 1'b0, 32'h0000_00AB, MD, 1,
             mk(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0100, 32'hABAB_ABAB, 32'h2000_0000, 1'b1, 2, 3));
      runAcc(1'b1, 32'h2000_0004, 2'd3, 1'b0, 32'hDEAD_BEEF, MD, 0,
             mk(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1111, 32'hDEAD_BEEF, 32'h2000_0004, 1'b1, 1, 2));

      // Alignment faults: no memory request, done+misalign next cycle.
      runAcc(1'b0, 32'h1000_0002, 2'd3, 1'b0, WD, MD, 0,
             mk(32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b0, 0, 1));
      runAcc(1'b0, 32'h1000_0000, 2'd2, 1'b0, WD, MD, 0,
             mk(32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b0, 0, 1));
      runAcc(1'b1, 32'h1000_0001, 2'd1, 1'b0, WD, MD, 0,
             mk(32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b0, 0, 1));

      // Timeout: no ack gives buserr; ack in the 15th cycle completes normally.
      runAcc(1'b0, 32'h3000_0000, 2'd3, 1'b0, WD, MD, -1,
             mk(32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1111, WD, 32'h3000_0000, 1'b0, 15, 16));
      runAcc(1'b0, 32'h3000_0000, 2'd3, 1'b0, WD, MD, 14,
             mk(MD, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1111, WD, 32'h3000_0000, 1'b0, 15, 16));

      // Asynchronous reset in the middle of an access.
      @(negedge clk);
      seenReq = 1'b0; reqCycles = 0; ackDelay = -1;
      req = 1'b1; wr = 1'b0; addr = 32'h3000_0000; DSize = 2'd3;
      repeat (3) @(posedge clk);
      #1 chk("mem_req_before_reset", 32'(mem_req), 32'd1);
      #1 reset = 1'b1;
      #1 chk("mem_req_async_reset", 32'(mem_req), 32'd0);
      chk("done_async_reset", 32'(done), 32'd0);
      #1 reset = 1'b0;
      req = 1'b0;
      runAcc(1'b0, 32'h1000_0001, 2'd0, 1'b1, WD, MD, 0,
             mk(32'h0000_0023, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0100, 32'h4444_4444, 32'h1000_0000, 1'b0, 1, 2));

      repeat (4) @(negedge clk);
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 15, max cycles waiting for mem_ack before bus error.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req  input  1  CPU access request; held high until done.
REQ-005 wr  input  1  1 = store, 0 = load.
REQ-006 addr  input  32  byte address, [0:31], byte offset = addr[30:31].
REQ-007 DSize  input  2  0 = byte, 1 = half, 3 = word, 2 = illegal.
REQ-008 loadSign  input  1  1 = sign-extend load, 0 = zero-extend.
REQ-009 wdata  input  32  store data, [0:31], right-justified for byte/half.
REQ-010 stall  output  1  freezes CPU pipeline while access outstanding.
REQ-011 done  output  1  one-cycle pulse, access finished.
REQ-012 rdata  output  32  aligned, extended load result, valid while done=1.
REQ-013 misalign  output  1  one-cycle pulse with done, alignment/size fault.
REQ-014 buserr  output  1  one-cycle pulse with done, timeout fault.
REQ-015 mem_req, mem_wr  output  1 each  memory request and write strobe.
REQ-016 mem_addr  output  32  word address, addr with [30:31] forced to 0.
REQ-017 mem_be  output  4  byte enables; mem_be[0] = offset 0 = data bits [0:7].
REQ-018 mem_wdata  output  32  lane-replicated store data.
REQ-019 mem_rdata  input  32  memory read word, big-endian lanes.
REQ-020 mem_ack  input  1  memory completion, one cycle.

Function
REQ-021 FSM states IDLE, ACCESS, RESP; IDLE samples req each cycle.
REQ-022 IDLE with req=1: capture wr, addr, DSize, loadSign, wdata; go to ACCESS if aligned, else RESP with fault.
REQ-023 Fault: DSize=2, half at odd offset, or word at offset!=0; no memory request issued, rdata=0.
REQ-024 ACCESS: mem_req=1, mem_wr=captured wr, mem_addr/mem_be/mem_wdata from captured values, stable until exit.
REQ-025 ACCESS with mem_ack=1: capture mem_rdata, go to RESP; minimum latency req-to-done = 2 cycles (ack on first ACCESS cycle).
REQ-026 ACCESS timeout counter starts at 0 on entry, increments per cycle without ack; at TIMEOUT go to RESP with buserr; ack on the same cycle as timeout wins (no buserr).
REQ-027 RESP: done=1 for exactly one cycle, misalign/buserr as latched, then IDLE.
REQ-028 stall = req AND NOT done (combinational).
REQ-029 Byte enables: byte -> one-hot at offset; half -> 1100 (offset 0) or 0011 (offset 2); word -> 1111; loads drive same mem_be.
REQ-030 Store data: byte -> wdata[24:31] replicated to all four lanes; half -> wdata[16:31] replicated to both halves; word -> wdata unchanged.
REQ-031 Load: selected lane(s) right-justified into rdata[24:31] (byte) or rdata[16:31] (half); upper bits = lane MSB if loadSign=1 else 0; word ignores loadSign.
REQ-032 mem_ack outside ACCESS ignored; req dropping during ACCESS does not abort the access.
REQ-033 Request presented in the IDLE cycle after RESP is accepted (one idle cycle between accesses).

Reset
REQ-034 reset=1 forces IDLE immediately, independent of clk; mid-access reset drops mem_req without waiting for ack.
REQ-035 Reset values: done, misalign, buserr, mem_req, mem_wr = 0; mem_be = 0000; mem_addr, mem_wdata, rdata = 0; timeout counter = 0.

Verification
REQ-036 Load byte, addr=0x1000_0001, loadSign=1, mem_rdata=0xF1234567, ack 3 cycles after mem_req -> mem_be=0100, rdata=0x00000023; with addr offset 0 -> rdata=0xFFFFFFF1.
REQ-037 Load half offset 0, loadSign=0/1, mem_rdata=0xF1234567 -> rdata=0x0000F123 / 0xFFFFF123; word load -> 0xF1234567 either sign.
REQ-038 Store half offset 2, wdata=0xAAAA5678 -> mem_be=0011, mem_wdata=0x56785678, mem_wr=1, done 1 cycle after ack.
REQ-039 Word load addr=0x...02 or DSize=2 -> mem_req never asserted, done+misalign pulse on cycle after req, rdata=0.
REQ-040 No ack for 15 cycles -> mem_req drops, done+buserr pulse; ack on the 15th cycle -> normal done, no buserr.
REQ-041 reset pulsed mid-ACCESS between clock edges -> mem_req=0 immediately, no done; next req after reset completes normally.
